// File: rtl/gate_exerciser_if.sv
// Bus between gate_exerciser and its surroundings: run control, gate stimulus/response, results.
// slave = exerciser side, master = controlling/observing side.
interface gate_exerciser_if;
    logic       start;
    logic       y_in;
    logic       a_out;
    logic       b_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_cnt;
    logic [3:0] fail_vec;

    modport slave (
        input  start, y_in,
        output a_out, b_out, busy, done, pass, err_cnt, fail_vec
    );

    modport master (
        output start, y_in,
        input  a_out, b_out, busy, done, pass, err_cnt, fail_vec
    );
endinterface

// File: rtl/gate_exerciser.sv
// Walks a 2-input NAND under test through its truth table, counts mismatches and reports pass/fail.
// Per-vector fail capture is built only when GATE_EXERCISER_FAIL_CAPTURE_EN is defined.
module gate_exerciser #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned LOOPS         = 1
) (
    input  logic            clk,
    input  logic            rst,
    gate_exerciser_if.slave ifc
);
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_e;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] LOOP_LAST   = 8'(LOOPS - 1);

    state_e     state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [7:0] loop_q, loop_d;
    logic [7:0] settle_q, settle_d;
    logic [7:0] err_q, err_d;
    logic       a_q, a_d, b_q, b_d;
    logic       busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic       accept;
    logic       mismatch;

    assign accept   = (state_q == IDLE) && ifc.start;
    assign mismatch = (state_q == SAMPLE) && (ifc.y_in != ~(a_q & b_q));

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        loop_d   = loop_q;
        settle_d = settle_q;
        err_d    = err_q;
        pass_d   = pass_q;
        case (state_q)
            IDLE: begin
                if (ifc.start) begin
                    state_d  = SETTLE;
                    vec_d    = '0;
                    loop_d   = '0;
                    settle_d = '0;
                    err_d    = '0;
                    pass_d   = 1'b0;
                end
            end
            SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d  = SAMPLE;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
            SAMPLE: begin
                if (mismatch && (err_q != '1)) err_d = err_q + 8'd1;
                if (vec_q != 2'd3) begin
                    vec_d   = vec_q + 2'd1;
                    state_d = SETTLE;
                end else if (loop_q < LOOP_LAST) begin
                    vec_d   = '0;
                    loop_d  = loop_q + 8'd1;
                    state_d = SETTLE;
                end else begin
                    // pass must reflect the final sample, so it is taken from err_d
                    state_d = DONE;
                    pass_d  = (err_d == '0);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        a_d    = ((state_d == SETTLE) || (state_d == SAMPLE)) && vec_d[1];
        b_d    = ((state_d == SETTLE) || (state_d == SAMPLE)) && vec_d[0];
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            vec_q    <= '0;
            loop_q   <= '0;
            settle_q <= '0;
            err_q    <= '0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            loop_q   <= loop_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            a_q      <= a_d;
            b_q      <= b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

`ifdef GATE_EXERCISER_FAIL_CAPTURE_EN
    logic [3:0] fail_q, fail_d;

    always_comb begin
        fail_d = fail_q;
        if (accept) begin
            fail_d = '0;
        end else if (mismatch) begin
            fail_d[vec_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fail_q <= '0;
        else     fail_q <= fail_d;
    end

    assign ifc.fail_vec = fail_q;
`else
    assign ifc.fail_vec = '0;
`endif

    assign ifc.a_out   = a_q;
    assign ifc.b_out   = b_q;
    assign ifc.busy    = busy_q;
    assign ifc.done    = done_q;
    assign ifc.pass    = pass_q;
    assign ifc.err_cnt = err_q;
endmodule
